// File: rtl/stop_watch_display.sv
// Stopwatch digit display: 7-segment decode, debounced LAP freeze/resume button,
// and a one-cycle pulse on every change of the incoming count.
module stop_watch_display #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [2:0] Q_in,
    input  logic       Lap_n,
    output logic [6:0] HEX,
    output logic       Hold,
    output logic       Digit_Change
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_LIVE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [6:0] SEG_ZERO  = 7'b0111111;
    localparam logic [6:0] HEX_RESET = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d, stable_prev_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q;
    logic [0:0]       state_q, state_d;
    logic [2:0]       disp_q, disp_d;
    logic [6:0]       hex_q, hex_d;
    logic [2:0]       q_prev_q;
    logic             chg_q;

    function automatic logic [6:0] seg_decode(input logic [2:0] val);
        case (val)
            3'd0:    seg_decode = SEG_ZERO;
            3'd1:    seg_decode = 7'b0000110;
            3'd2:    seg_decode = 7'b1011011;
            3'd3:    seg_decode = 7'b1001111;
            3'd4:    seg_decode = 7'b1100110;
            3'd5:    seg_decode = 7'b1101101;
            default: seg_decode = 7'b1000000;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        deb_cnt_d = '0;
        stable_d  = stable_q;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == CNT_LAST) stable_d = sync2_q;
            else                       deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        case (state_q)
            ST_LIVE: begin
                disp_d = Q_in;
                if (press_q) state_d = ST_HOLD;
            end
            ST_HOLD: if (press_q) state_d = ST_LIVE;
            default: state_d = ST_LIVE;
        endcase
        hex_d = SEG_ACTIVE_LOW ? ~seg_decode(disp_q) : seg_decode(disp_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            deb_cnt_q     <= '0;
            press_q       <= 1'b0;
            state_q       <= ST_LIVE;
            disp_q        <= 3'd0;
            hex_q         <= HEX_RESET;
            q_prev_q      <= 3'd0;
            chg_q         <= 1'b0;
        end else begin
            sync1_q       <= Lap_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
            // Only the accepted falling edge (press) is an event; releases are ignored.
            press_q       <= stable_prev_q & ~stable_q;
            state_q       <= state_d;
            disp_q        <= disp_d;
            hex_q         <= hex_d;
            q_prev_q      <= Q_in;
            chg_q         <= (Q_in != q_prev_q);
        end
    end

    assign HEX          = hex_q;
    assign Hold         = (state_q == ST_HOLD);
    assign Digit_Change = chg_q;

endmodule
